tie_expstate_arbiter: RTL and testbench

//   Shares one TIE import wire between NUM_SRC TIE export-state sources in the XTSC

---
 rtl/tie_expstate_arbiter.sv | 142 ++++++++++++++
 tb/tb_tie_expstate_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tie_expstate_arbiter.sv
// tie_expstate_arbiter: captures value changes on NUM_SRC TIE export states and
// round-robin grants the latest pending value onto one import wire with a minimum dwell.
`default_nettype none

module tie_expstate_arbiter #(
  parameter int WIDTH       = 32,
  parameter int NUM_SRC     = 2,
  parameter int SRC_W       = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_SRC*WIDTH-1:0] TIE_EXPSTATE,
  input  logic                     ARB_EN,
  output logic [WIDTH-1:0]         TIE_IMPWIRE,
  output logic [SRC_W-1:0]         IMPWIRE_SRC,
  output logic                     IMPWIRE_UPDATE,
  output logic [NUM_SRC-1:0]       PENDING,
  output logic [7:0]               OVERRUN_CNT
);

  localparam int CNT_W = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRC_W-1:0]   rr_q;
  logic [WIDTH-1:0]   prev_q   [NUM_SRC];
  logic [WIDTH-1:0]   shadow_q [NUM_SRC];

  logic [NUM_SRC-1:0] changed;
  logic [NUM_SRC-1:0] overrun;
  logic               grant_valid;
  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [9:0]         ovr_sum;
  logic [7:0]         ovr_next;

  always_comb begin
    changed = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      changed[i] = (TIE_EXPSTATE[i*WIDTH +: WIDTH] != prev_q[i]);
    end
  end

  // Scan downwards so the pending source closest to the RR pointer wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_SRC;
      if (PENDING[idx]) begin
        grant_idx   = SRC_W'(idx);
        grant_found = 1'b1;
      end
    end
    grant_valid = (state_q == IDLE) && ARB_EN && grant_found;
  end

  // A change on the source being granted this cycle is a collision, not an overrun.
  always_comb begin
    overrun = '0;
    ovr_sum = {2'b00, OVERRUN_CNT};
    for (int i = 0; i < NUM_SRC; i++) begin
      overrun[i] = changed[i] && PENDING[i] && !(grant_valid && (grant_idx == SRC_W'(i)));
      ovr_sum    = ovr_sum + 10'(overrun[i]);
    end
    ovr_next = (ovr_sum > 10'd255) ? 8'hFF : ovr_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid && (HOLD_CYCLES != 0)) begin
          state_d = HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      TIE_IMPWIRE    <= '0;
      IMPWIRE_SRC    <= '0;
      IMPWIRE_UPDATE <= 1'b0;
      PENDING        <= '0;
      OVERRUN_CNT    <= '0;
      rr_q           <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        prev_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      IMPWIRE_UPDATE <= grant_valid;
      OVERRUN_CNT    <= ovr_next;
      if (grant_valid) begin
        TIE_IMPWIRE <= shadow_q[grant_idx];
        IMPWIRE_SRC <= grant_idx;
        rr_q        <= SRC_W'((int'(grant_idx) + 1) % NUM_SRC);
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (changed[i]) begin
          prev_q[i]   <= TIE_EXPSTATE[i*WIDTH +: WIDTH];
          shadow_q[i] <= TIE_EXPSTATE[i*WIDTH +: WIDTH];
          PENDING[i]  <= 1'b1;
        end else if (grant_valid && (grant_idx == SRC_W'(i))) begin
          PENDING[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tie_expstate_arbiter.sv
// Bench for tie_expstate_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model (grant spacing tracked by edge number).
`default_nettype none

module tb_tie_expstate_arbiter;

  localparam int WIDTH       = 32;
  localparam int NUM_SRC     = 3;
  localparam int SRC_W       = 2;
  localparam int HOLD_CYCLES = 2;
  localparam int VW          = NUM_SRC * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic [VW-1:0]    exp_in;
  logic             arb_en;
  logic [WIDTH-1:0] impwire;
  logic [SRC_W-1:0] imp_src;
  logic             imp_upd;
  logic [NUM_SRC-1:0] pending;
  logic [7:0]       ovr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tie_expstate_arbiter #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .CLK(clk), .RESET(rst), .TIE_EXPSTATE(exp_in), .ARB_EN(arb_en),
    .TIE_IMPWIRE(impwire), .IMPWIRE_SRC(imp_src), .IMPWIRE_UPDATE(imp_upd),
    .PENDING(pending), .OVERRUN_CNT(ovr_cnt)
  );

  // Reference model state
  logic [WIDTH-1:0]   m_prev   [NUM_SRC];
  logic [WIDTH-1:0]   m_shadow [NUM_SRC];
  logic [NUM_SRC-1:0] m_pend;
  logic [WIDTH-1:0]   m_imp;
  int m_src, m_upd, m_ovr, m_rr, m_next_ok, m_edge;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic [VW-1:0] v);
    int g;
    logic [WIDTH-1:0] cur;
    m_edge++;
    if (r) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        m_prev[i] = '0;
        m_shadow[i] = '0;
      end
      m_pend = '0; m_imp = '0; m_src = 0; m_upd = 0; m_ovr = 0; m_rr = 0; m_next_ok = 0;
    end else begin
      g = -1;
      if (en && (m_edge >= m_next_ok) && (m_pend != 0)) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (g < 0 && m_pend[(m_rr + k) % NUM_SRC]) g = (m_rr + k) % NUM_SRC;
        end
      end
      m_upd = 0;
      if (g >= 0) begin
        m_imp = m_shadow[g];
        m_src = g;
        m_upd = 1;
        m_pend[g] = 1'b0;
        m_rr = (g + 1) % NUM_SRC;
        m_next_ok = m_edge + HOLD_CYCLES + 1;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        cur = v[i*WIDTH +: WIDTH];
        if (cur != m_prev[i]) begin
          if (m_pend[i] && i != g && m_ovr < 255) m_ovr++;
          m_prev[i] = cur;
          m_shadow[i] = cur;
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_val("impwire", 64'(impwire), 64'(m_imp));
    check_val("imp_src", 64'(imp_src), 64'(m_src));
    check_val("imp_upd", 64'(imp_upd), 64'(m_upd));
    check_val("pending", 64'(pending), 64'(m_pend));
    check_val("ovr_cnt", 64'(ovr_cnt), 64'(m_ovr));
  endtask

  task automatic cycle(input logic r, input logic en, input logic [VW-1:0] v);
    @(negedge clk);
    rst = r;
    arb_en = en;
    exp_in = v;
    model_step(r, en, v);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [VW-1:0] pack3(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                                          input logic [WIDTH-1:0] s2);
    return {s2, s1, s0};
  endfunction

  initial begin
    logic [VW-1:0] v;
    int ovr0;
    rst = 1'b1; arb_en = 1'b0; exp_in = '0;
    m_edge = 0;
    model_step(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    check_val("reset_imp", 64'(impwire), 64'h0);
    check_val("reset_pend", 64'(pending), 64'h0);

    // Single change, two-cycle latency
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);
    v = pack3(32'hA5A5_0001, 0, 0);
    cycle(1'b0, 1'b1, v);
    check_val("t1_upd_early", 64'(imp_upd), 64'h0);
    cycle(1'b0, 1'b1, v);
    check_val("t1_imp", 64'(impwire), 64'hA5A5_0001);
    check_val("t1_upd", 64'(imp_upd), 64'h1);
    cycle(1'b0, 1'b1, v);
    check_val("t1_upd_pulse", 64'(imp_upd), 64'h0);
    check_val("t1_pend", 64'(pending), 64'h0);

    // Simultaneous changes: src0 first, src1 HOLD_CYCLES+1 later
    cycle(1'b1, 1'b1, '0);
    v = pack3(32'h11, 32'h22, 0);
    cycle(1'b0, 1'b1, v);
    cycle(1'b0, 1'b1, v);
    check_val("t2_first", 64'(impwire), 64'h11);
    cycle(1'b0, 1'b1, v);
    cycle(1'b0, 1'b1, v);
    check_val("t2_hold_upd", 64'(imp_upd), 64'h0);
    cycle(1'b0, 1'b1, v);
    check_val("t2_second", 64'(impwire), 64'h22);
    check_val("t2_second_src", 64'(imp_src), 64'h1);

    // Overrun while disabled, then one grant of latest value
    ovr0 = int'(ovr_cnt);
    cycle(1'b0, 1'b0, pack3(32'h11, 32'h1, 0));
    cycle(1'b0, 1'b0, pack3(32'h11, 32'h2, 0));
    cycle(1'b0, 1'b0, pack3(32'h11, 32'h3, 0));
    check_val("t3_ovr", 64'(ovr_cnt), 64'(ovr0 + 2));
    cycle(1'b0, 1'b1, pack3(32'h11, 32'h3, 0));
    check_val("t3_grant", 64'(impwire), 64'h3);

    // Grant/change collision
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, pack3(32'h4, 0, 0));
    cycle(1'b0, 1'b1, pack3(32'h5, 0, 0));
    check_val("t4_old", 64'(impwire), 64'h4);
    check_val("t4_pend", 64'(pending), 64'h1);
    cycle(1'b0, 1'b1, pack3(32'h5, 0, 0));
    cycle(1'b0, 1'b1, pack3(32'h5, 0, 0));
    cycle(1'b0, 1'b1, pack3(32'h5, 0, 0));
    check_val("t4_new", 64'(impwire), 64'h5);
    check_val("t4_ovr", 64'(ovr_cnt), 64'h0);

    // Reset mid-HOLD with a source pending
    cycle(1'b1, 1'b0, '0);
    v = pack3(0, 32'h7, 0);
    cycle(1'b0, 1'b1, v);
    v = pack3(32'h9, 32'h7, 0);
    cycle(1'b0, 1'b1, v);
    cycle(1'b1, 1'b1, v);
    check_val("t5_upd", 64'(imp_upd), 64'h0);
    check_val("t5_imp", 64'(impwire), 64'h0);
    check_val("t5_pend", 64'(pending), 64'h0);
    cycle(1'b0, 1'b0, v);
    check_val("t5_redetect", 64'(pending), 64'h3);

    // Saturation
    for (int i = 0; i < 302; i++) cycle(1'b0, 1'b0, pack3(WIDTH'(i + 100), 32'h7, 0));
    check_val("t6_sat", 64'(ovr_cnt), 64'd255);

    // Random traffic
    cycle(1'b1, 1'b0, '0);
    v = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if ($urandom_range(0, 2) == 0) v[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 5));
      end
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) != 0), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
